// File: rtl/fsrc_tx_buf_pkg.sv
`default_nettype none
// ============================================================================
// fsrc_tx_buf_pkg : shared types and defaults for the TX FSRC stream buffer
// Revision 1.0
// ============================================================================
package fsrc_tx_buf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int DEF_CNT_WIDTH = 16;

endpackage
`default_nettype wire

// File: rtl/fsrc_tx_buf_ram.sv
`default_nettype none
// ============================================================================
// fsrc_tx_buf_ram : simple dual-port storage, synchronous read, no array reset
// Revision 1.0
// ============================================================================
module fsrc_tx_buf_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // The read register holds its value unless a new read is issued, which is
  // what keeps the downstream data stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/fsrc_tx_stream_buffer.sv
`default_nettype none
// ============================================================================
// fsrc_tx_stream_buffer : prefilling elastic buffer feeding the TX FSRC input
// Optional build macro FSRC_TX_BUF_ZERO_FILL_EN: emit zero beats on underflow.
// Revision 1.0
// ============================================================================
module fsrc_tx_stream_buffer
  import fsrc_tx_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [ADDR_WIDTH:0]   prefill_level,
  input  logic                  underflow_clr,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  underflow,
  output logic [CNT_WIDTH-1:0]  underflow_count
);

  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  out_valid_q, out_valid_d;
  logic                  underflow_q, underflow_d;
  logic [CNT_WIDTH-1:0]  uf_cnt_q, uf_cnt_d;

  logic                  wr_en;
  logic                  rd_en;
  logic                  uf_event;
  logic                  zero_beat;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  assign s_axis_ready = (state_q != IDLE) && (level_q != FULL_LEVEL);
  assign wr_en        = s_axis_valid && s_axis_ready;

  // The RAM read register doubles as the output register, giving the
  // two-cycle write-to-output latency with a synchronous-read array.
  assign rd_en    = (state_q == RUN) && (level_q != '0) && (!out_valid_q || m_axis_ready);
  assign uf_event = (state_q == RUN) && m_axis_ready && !out_valid_q;

`ifdef FSRC_TX_BUF_ZERO_FILL_EN
  assign zero_beat = uf_event && (level_q == '0);
`else
  assign zero_beat = 1'b0;
`endif

  assign m_axis_valid    = out_valid_q || zero_beat;
  assign m_axis_data     = out_valid_q ? ram_rd_data : '0;
  assign level           = level_q;
  assign underflow       = underflow_q;
  assign underflow_count = uf_cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (enable) state_d = FILL;
      FILL: if ((level_q >= prefill_level) || (level_q == FULL_LEVEL)) state_d = RUN;
      RUN:  state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_valid_d = out_valid_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + (ADDR_WIDTH+1)'(1);
      2'b01:   level_d = level_q - (ADDR_WIDTH+1)'(1);
      default: level_d = level_q;
    endcase
    if (rd_en) begin
      out_valid_d = 1'b1;
    end else if (m_axis_ready) begin
      out_valid_d = 1'b0;
    end
    if (!enable) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      out_valid_d = 1'b0;
    end
  end

  // An event coinciding with a clear restarts the count at one.
  always_comb begin
    underflow_d = underflow_q;
    uf_cnt_d    = uf_cnt_q;
    if (uf_event) begin
      underflow_d = 1'b1;
      if (underflow_clr) begin
        uf_cnt_d = CNT_WIDTH'(1);
      end else if (uf_cnt_q != '1) begin
        uf_cnt_d = uf_cnt_q + CNT_WIDTH'(1);
      end
    end else if (underflow_clr) begin
      underflow_d = 1'b0;
      uf_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      underflow_q <= 1'b0;
      uf_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      underflow_q <= underflow_d;
      uf_cnt_q    <= uf_cnt_d;
    end
  end

  fsrc_tx_buf_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (s_axis_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_fsrc_tx_stream_buffer.sv
`default_nettype none
// ============================================================================
// tb_fsrc_tx_stream_buffer : directed scoreboard bench for the TX stream buffer
// Revision 1.0
// ============================================================================
module tb_fsrc_tx_stream_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [5:0]  prefill_level;
  logic        underflow_clr;
  logic        s_axis_valid;
  logic        s_axis_ready;
  logic [63:0] s_axis_data;
  logic        m_axis_valid;
  logic        m_axis_ready;
  logic [63:0] m_axis_data;
  logic [5:0]  level;
  logic        underflow;
  logic [15:0] underflow_count;

  typedef struct packed {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;
  int   cyc;
  int   src_total;
  int   src_sent;
  int   n_real;

  fsrc_tx_stream_buffer #(
    .DATA_WIDTH (64),
    .ADDR_WIDTH (5),
    .CNT_WIDTH  (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .prefill_level   (prefill_level),
    .underflow_clr   (underflow_clr),
    .s_axis_valid    (s_axis_valid),
    .s_axis_ready    (s_axis_ready),
    .s_axis_data     (s_axis_data),
    .m_axis_valid    (m_axis_valid),
    .m_axis_ready    (m_axis_ready),
    .m_axis_data     (m_axis_data),
    .level           (level),
    .underflow       (underflow),
    .underflow_count (underflow_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] beat(input int idx);
    return {32'h5EED_0000, 32'(idx)};
  endfunction

  // DMA source: offers beats 0..src_total-1, pushes each accepted beat.
  initial begin
    s_axis_valid = 1'b0;
    s_axis_data  = '0;
    forever begin
      @(negedge clk);
      if (!reset && enable && s_axis_valid && s_axis_ready) begin
        exp_q.push_back('{data: s_axis_data, cyc: cyc});
        src_sent++;
      end
      @(posedge clk);
      #2;
      s_axis_valid = (src_sent < src_total);
      s_axis_data  = beat(src_sent);
    end
  end

  // Monitor: every delivered beat must match the oldest beat that is due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && m_axis_valid && m_axis_ready) begin
        if (exp_q.size() != 0 && (exp_q[0].cyc + 2 <= cyc)) begin
          e = exp_q.pop_front();
          n_real++;
          chk("m_axis_data", m_axis_data, e.data);
        end else begin
`ifdef FSRC_TX_BUF_ZERO_FILL_EN
          chk("zero_beat_data", m_axis_data, 64'h0);
`else
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got data %0h with no beat due (cycle %0d)", m_axis_data, cyc);
`endif
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int real0;
    reset         = 1'b1;
    enable        = 1'b0;
    prefill_level = 6'd0;
    underflow_clr = 1'b0;
    m_axis_ready  = 1'b0;
    src_total     = 0;
    repeat (3) tick();

    chk("rst_s_ready", 64'(s_axis_ready), 64'd0);
    chk("rst_m_valid", 64'(m_axis_valid), 64'd0);
    chk("rst_m_data", m_axis_data, 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_underflow", 64'(underflow), 64'd0);
    chk("rst_count", 64'(underflow_count), 64'd0);
    reset = 1'b0;
    tick();

    // Prefill of 4 with a continuous source and a ready consumer
    enable        = 1'b1;
    prefill_level = 6'd4;
    m_axis_ready  = 1'b1;
    src_total     = 12;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("fill_m_valid", 64'(m_axis_valid), 64'd0);
      if (i == 1) chk("fill_s_ready", 64'(s_axis_ready), 64'd1);
      if (i == 5) chk("fill_level", 64'(level), 64'd4);
    end
    tick();
    chk("first_m_valid", 64'(m_axis_valid), 64'd1);
    chk("first_m_data", m_axis_data, beat(0));
    repeat (25) tick();
    chk("t1_all_delivered", 64'(n_real), 64'd12);
    chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);

    // Underflow counting and clear priority
    m_axis_ready  = 1'b0;
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    chk("clr_count", 64'(underflow_count), 64'd0);
    chk("clr_flag", 64'(underflow), 64'd0);
    m_axis_ready = 1'b1;
    repeat (3) tick();
    m_axis_ready = 1'b0;
    chk("uf3_count", 64'(underflow_count), 64'd3);
    chk("uf3_flag", 64'(underflow), 64'd1);
    m_axis_ready  = 1'b1;
    underflow_clr = 1'b1;
    tick();
    m_axis_ready  = 1'b0;
    underflow_clr = 1'b0;
    chk("clr_evt_count", 64'(underflow_count), 64'd1);
    chk("clr_evt_flag", 64'(underflow), 64'd1);
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    chk("clr_only_count", 64'(underflow_count), 64'd0);
    chk("clr_only_flag", 64'(underflow), 64'd0);

    // Two-cycle latency of a single beat into empty storage
    base         = src_total;
    m_axis_ready = 1'b1;
    src_total    = src_total + 1;
    tick();
    chk("lat_n1_valid", 64'(m_axis_valid), 64'd0);
    tick();
    chk("lat_n2_valid", 64'(m_axis_valid), 64'd1);
    chk("lat_n2_data", m_axis_data, beat(base));
    tick();

    // Empty storage with a ready consumer
    m_axis_ready  = 1'b0;
    underflow_clr = 1'b1;
    tick();
    underflow_clr = 1'b0;
    m_axis_ready  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1;
`ifdef FSRC_TX_BUF_ZERO_FILL_EN
      chk("zf_valid", 64'(m_axis_valid), 64'd1);
`else
      chk("nozf_valid", 64'(m_axis_valid), 64'd0);
`endif
      chk("empty_data", m_axis_data, 64'd0);
      tick();
      chk("empty_count", 64'(underflow_count), 64'(i));
    end
    m_axis_ready = 1'b0;

    // Fill to DEPTH with the consumer stalled, then free a single slot
    enable = 1'b0;
    tick();
    exp_q.delete();
    base          = src_total;
    enable        = 1'b1;
    prefill_level = 6'd63;
    src_total     = src_total + 40;
    repeat (32) tick();
    chk("full_m1_level", 64'(level), 64'd31);
    chk("full_m1_s_ready", 64'(s_axis_ready), 64'd1);
    tick();
    chk("full_level", 64'(level), 64'd32);
    chk("full_s_ready", 64'(s_axis_ready), 64'd0);
    chk("full_m_valid", 64'(m_axis_valid), 64'd0);
    chk("full_accepted", 64'(src_sent - base), 64'd32);
    repeat (3) tick();
    chk("run_full_level", 64'(level), 64'd32);
    chk("run_full_s_ready", 64'(s_axis_ready), 64'd0);
    chk("hold_m_valid", 64'(m_axis_valid), 64'd1);
    chk("hold_data_a", m_axis_data, beat(base));
    tick();
    chk("hold_data_b", m_axis_data, beat(base));
    m_axis_ready = 1'b1;
    tick();
    m_axis_ready = 1'b0;
    chk("one_read_level", 64'(level), 64'd31);
    chk("one_read_s_ready", 64'(s_axis_ready), 64'd1);
    chk("one_read_next", m_axis_data, beat(base + 1));
    tick();
    chk("refill_level", 64'(level), 64'd32);
    chk("refill_s_ready", 64'(s_axis_ready), 64'd0);
    chk("refill_accepted", 64'(src_sent - base), 64'd34);
    enable    = 1'b0;
    src_total = src_sent;
    tick();
    exp_q.delete();
    chk("flush32_level", 64'(level), 64'd0);

    // Enable dropped with level 10; old data must never reappear
    enable    = 1'b1;
    src_total = src_total + 10;
    repeat (12) tick();
    chk("pre_flush_level", 64'(level), 64'd10);
    enable = 1'b0;
    tick();
    exp_q.delete();
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_m_valid", 64'(m_axis_valid), 64'd0);
    chk("flush_s_ready", 64'(s_axis_ready), 64'd0);
    real0         = n_real;
    enable        = 1'b1;
    prefill_level = 6'd2;
    m_axis_ready  = 1'b1;
    src_total     = src_total + 3;
    tick();
    chk("reen_m_valid", 64'(m_axis_valid), 64'd0);
    repeat (15) tick();
    chk("reen_delivered", 64'(n_real - real0), 64'd3);
    chk("reen_queue_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset while a beat is presented
    m_axis_ready = 1'b0;
    src_total    = src_total + 2;
    repeat (6) tick();
    chk("pre_rst_m_valid", 64'(m_axis_valid), 64'd1);
    chk("pre_rst_level", 64'(level), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_m_valid", 64'(m_axis_valid), 64'd0);
    chk("arst_m_data", m_axis_data, 64'd0);
    chk("arst_s_ready", 64'(s_axis_ready), 64'd0);
    chk("arst_level", 64'(level), 64'd0);
    chk("arst_underflow", 64'(underflow), 64'd0);
    chk("arst_count", 64'(underflow_count), 64'd0);
    reset = 1'b0;
    exp_q.delete();
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
